// File: rtl/tmr_fault_monitor.sv
// rtl/tmr_fault_monitor.sv - TMR replica voter with per-replica health FSMs, saturating fault stats and IRQ
// Optional fault log outputs (last_fault_id/last_fault_val) are enabled by defining TMR_FAULT_LOG_EN.
module tmr_fault_monitor #(
  parameter int width       = 16,
  parameter int CNT_W       = 8,
  parameter int FAIL_THR    = 3,
  parameter int RECOVER_THR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             clr_stats,
  input  logic [width-1:0] q_1,
  input  logic [width-1:0] q_2,
  input  logic [width-1:0] q_3,
  output logic [width-1:0] voted_q,
  output logic             valid_out,
  output logic [CNT_W-1:0] fault_cnt_1,
  output logic [CNT_W-1:0] fault_cnt_2,
  output logic [CNT_W-1:0] fault_cnt_3,
  output logic [5:0]       replica_state,
  output logic [2:0]       replica_failed,
  output logic             no_majority,
  output logic [CNT_W-1:0] nm_cnt,
`ifdef TMR_FAULT_LOG_EN
  output logic [1:0]       last_fault_id,
  output logic [width-1:0] last_fault_val,
`endif
  output logic             fault_irq
);

  typedef enum logic [1:0] {
    HEALTHY = 2'b00,
    SUSPECT = 2'b01,
    FAILED  = 2'b10,
    UNUSED  = 2'b11
  } rstate_t;

  localparam logic [3:0]       FT      = 4'(FAIL_THR);
  localparam logic [3:0]       RT      = 4'(RECOVER_THR);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rstate_t          st [3];
  logic [3:0]       fs [3];
  logic [3:0]       ms [3];
  logic [CNT_W-1:0] fc [3];
  logic [width-1:0] qv [3];
  logic [width-1:0] maj;
  logic             nm;
  logic [2:0]       mism;
  logic [2:0]       fail_enter;

  assign qv[0] = q_1;
  assign qv[1] = q_2;
  assign qv[2] = q_3;

  always_comb begin
    maj = (q_1 & q_2) | (q_1 & q_3) | (q_2 & q_3);
    nm  = 1'b0;
    if (q_1 == q_2 || q_1 == q_3) maj = q_1;
    else if (q_2 == q_3)          maj = q_2;
    else                          nm  = 1'b1;
  end

  // Only samples that have a majority can charge a replica with a mismatch.
  always_comb begin
    mism       = 3'b000;
    fail_enter = 3'b000;
    for (int i = 0; i < 3; i++) begin
      mism[i]       = sample_en && !nm && (qv[i] != maj);
      fail_enter[i] = mism[i] && (st[i] == SUSPECT) && ((fs[i] + 4'd1) == FT);
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) replica_failed[i] = (st[i] == FAILED);
  end

  assign replica_state = {st[2], st[1], st[0]};
  assign fault_cnt_1   = fc[0];
  assign fault_cnt_2   = fc[1];
  assign fault_cnt_3   = fc[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      voted_q     <= '0;
      valid_out   <= 1'b0;
      no_majority <= 1'b0;
      nm_cnt      <= '0;
      fault_irq   <= 1'b0;
`ifdef TMR_FAULT_LOG_EN
      last_fault_id  <= 2'd0;
      last_fault_val <= '0;
`endif
      for (int i = 0; i < 3; i++) begin
        st[i] <= HEALTHY;
        fs[i] <= 4'd0;
        ms[i] <= 4'd0;
        fc[i] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      fault_irq <= 1'b0;
      if (clr_stats) begin
        no_majority <= 1'b0;
        nm_cnt      <= '0;
`ifdef TMR_FAULT_LOG_EN
        last_fault_id  <= 2'd0;
        last_fault_val <= '0;
`endif
        for (int i = 0; i < 3; i++) begin
          st[i] <= HEALTHY;
          fs[i] <= 4'd0;
          ms[i] <= 4'd0;
          fc[i] <= '0;
        end
      end else begin
        if (sample_en) begin
          voted_q   <= maj;
          valid_out <= 1'b1;
          if (nm) begin
            no_majority <= 1'b1;
            fault_irq   <= !no_majority;
            if (nm_cnt != CNT_MAX) nm_cnt <= nm_cnt + CNT_W'(1);
          end else begin
            fault_irq <= |fail_enter;
          end
`ifdef TMR_FAULT_LOG_EN
          if (nm) begin
            last_fault_id  <= 2'd3;
            last_fault_val <= q_1;
          end else if (mism[0]) begin
            last_fault_id  <= 2'd1;
            last_fault_val <= q_1;
          end else if (mism[1]) begin
            last_fault_id  <= 2'd2;
            last_fault_val <= q_2;
          end else if (mism[2]) begin
            last_fault_id  <= 2'd3;
            last_fault_val <= q_3;
          end
`endif
        end
        for (int i = 0; i < 3; i++) begin
          if (mism[i] && fc[i] != CNT_MAX) fc[i] <= fc[i] + CNT_W'(1);
          if (st[i] == UNUSED) begin
            st[i] <= HEALTHY;
            fs[i] <= 4'd0;
            ms[i] <= 4'd0;
          end else if (sample_en && !nm) begin
            case (st[i])
              HEALTHY: if (mism[i]) begin
                st[i] <= SUSPECT;
                fs[i] <= 4'd1;
                ms[i] <= 4'd0;
              end
              SUSPECT: if (mism[i]) begin
                fs[i] <= fs[i] + 4'd1;
                ms[i] <= 4'd0;
                if (fail_enter[i]) st[i] <= FAILED;
              end else begin
                fs[i] <= 4'd0;
                ms[i] <= ms[i] + 4'd1;
                if ((ms[i] + 4'd1) == RT) begin
                  st[i] <= HEALTHY;
                  ms[i] <= 4'd0;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb/tb_tmr_fault_monitor.sv - scoreboard bench for tmr_fault_monitor
module tb_tmr_fault_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_en = 1'b0;
  logic        clr_stats = 1'b0;
  logic [15:0] q_1 = '0, q_2 = '0, q_3 = '0;
  logic [15:0] voted_q;
  logic        valid_out;
  logic [7:0]  fault_cnt_1, fault_cnt_2, fault_cnt_3, nm_cnt;
  logic [5:0]  replica_state;
  logic [2:0]  replica_failed;
  logic        no_majority, fault_irq;
`ifdef TMR_FAULT_LOG_EN
  logic [1:0]  last_fault_id;
  logic [15:0] last_fault_val;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  tmr_fault_monitor dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .clr_stats(clr_stats),
    .q_1(q_1), .q_2(q_2), .q_3(q_3),
    .voted_q(voted_q), .valid_out(valid_out),
    .fault_cnt_1(fault_cnt_1), .fault_cnt_2(fault_cnt_2), .fault_cnt_3(fault_cnt_3),
    .replica_state(replica_state), .replica_failed(replica_failed),
    .no_majority(no_majority), .nm_cnt(nm_cnt),
`ifdef TMR_FAULT_LOG_EN
    .last_fault_id(last_fault_id), .last_fault_val(last_fault_val),
`endif
    .fault_irq(fault_irq)
  );

  // Scoreboard: every valid_out pops the oldest expected voted value.
  always @(negedge clk) begin
    if (rst && valid_out) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_valid: voted_q=%0d with nothing expected", voted_q);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (voted_q !== e) begin
          fails++;
          $display("FAIL sb_voted_q: got %0d expected %0d", voted_q, e);
        end
      end
    end
  end

  task automatic sample(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] ev);
    @(negedge clk);
    q_1 = a; q_2 = b; q_3 = c; sample_en = 1'b1;
    exp_q.push_back(ev);
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    tests++;
    if ({voted_q, valid_out, fault_cnt_1, fault_cnt_2, fault_cnt_3, replica_state,
         replica_failed, no_majority, nm_cnt, fault_irq} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: voted_q=%0h state=%0h cnt1=%0h", voted_q, replica_state, fault_cnt_1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_fault();
    sample(16'd5, 16'd5, 16'd7, 16'd5);
    chk("single_valid", valid_out, 1);
    chk("single_cnt3", fault_cnt_3, 1);
    chk("single_cnt12", {fault_cnt_1, fault_cnt_2}, 0);
    chk("single_state", replica_state, 6'b010000);
    chk("single_irq", fault_irq, 0);
    @(negedge clk);
    chk("single_valid_pulse", valid_out, 0);
  endtask

  task automatic test_failure();
    int irqs;
    clear();
    irqs = 0;
    for (int k = 0; k < 3; k++) begin
      sample(16'd9, 16'd8, 16'd9, 16'd9);
      if (fault_irq) irqs++;
      if (k == 0) chk("fail_state_s1", replica_state, 6'b000100);
    end
    chk("fail_state", replica_state, 6'b001000);
    chk("fail_failed", replica_failed, 3'b010);
    chk("fail_cnt2", fault_cnt_2, 3);
    chk("fail_irq_now", fault_irq, 1);
    @(negedge clk);
    chk("fail_irq_once", irqs, 1);
    chk("fail_irq_drop", fault_irq, 0);
  endtask

  task automatic test_reset_mid();
    #3 rst = 1'b0;
    #1;
    chk("rstmid_cnt2", fault_cnt_2, 0);
    chk("rstmid_state", replica_state, 0);
    chk("rstmid_failed", replica_failed, 0);
    chk("rstmid_voted", voted_q, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_recovery();
    sample(16'd4, 16'd6, 16'd6, 16'd6);
    chk("rec_suspect", replica_state, 6'b000001);
    for (int k = 0; k < 4; k++) begin
      sample(16'd6, 16'd6, 16'd6, 16'd6);
      if (k == 2) chk("rec_still_suspect", replica_state, 6'b000001);
    end
    chk("rec_healthy", replica_state, 0);
    chk("rec_cnt1", fault_cnt_1, 1);
  endtask

  task automatic test_no_majority();
    clear();
    sample(16'd5, 16'd5, 16'd7, 16'd5);
    sample(16'd1, 16'd2, 16'd4, 16'd0);
    chk("nm_flag", no_majority, 1);
    chk("nm_cnt1", nm_cnt, 1);
    chk("nm_irq", fault_irq, 1);
    chk("nm_cnt3_hold", fault_cnt_3, 1);
    chk("nm_state_hold", replica_state, 6'b010000);
    @(negedge clk);
    chk("nm_irq_drop", fault_irq, 0);
    sample(16'd1, 16'd2, 16'd4, 16'd0);
    chk("nm_cnt2", nm_cnt, 2);
    chk("nm_no_irq2", fault_irq, 0);
  endtask

  task automatic test_saturation();
    int irqs;
    clear();
    irqs = 0;
    for (int k = 0; k < 300; k++) begin
      sample(16'd3, 16'd0, 16'd0, 16'd0);
      if (fault_irq) irqs++;
    end
    chk("sat_cnt1", fault_cnt_1, 8'hff);
    chk("sat_state", replica_state, 6'b000010);
    chk("sat_failed", replica_failed, 3'b001);
    chk("sat_irqs", irqs, 1);
    @(negedge clk);
    q_1 = 16'd7; q_2 = 16'd7; q_3 = 16'd7;
    sample_en = 1'b1; clr_stats = 1'b1;
    @(negedge clk);
    sample_en = 1'b0; clr_stats = 1'b0;
    chk("clr_stats", {fault_cnt_1, fault_cnt_2, fault_cnt_3, nm_cnt, no_majority, replica_failed}, 0);
    chk("clr_state", replica_state, 0);
    chk("clr_valid", valid_out, 0);
    chk("clr_voted_hold", voted_q, 0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    q_1 = 16'd1; q_2 = 16'd1; q_3 = 16'd1; sample_en = 1'b1; exp_q.push_back(16'd1);
    @(negedge clk);
    q_1 = 16'd2; q_2 = 16'd2; q_3 = 16'd3; exp_q.push_back(16'd2);
    @(negedge clk);
    q_1 = 16'd4; q_2 = 16'd4; q_3 = 16'd4; exp_q.push_back(16'd4);
    @(negedge clk);
    sample_en = 1'b0;
    chk("b2b_cnt3", fault_cnt_3, 1);
    chk("b2b_state", replica_state, 6'b010000);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_single_fault();
    test_failure();
    test_reset_mid();
    test_recovery();
    test_no_majority();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tmr_fault_monitor.md
Name: tmr_fault_monitor

Overview:
- Sits directly downstream of the triplicated counters and their majority voter.
- Consumes the three replica values q_1/q_2/q_3 and produces a registered voted value.
- Tracks per-replica health through a small FSM, with saturating fault statistics.
- Raises an interrupt pulse when a replica is declared failed or when no majority exists.

Parameters:
- width, 16, bit width of each replica value.
- CNT_W, 8, width of each saturating statistics counter.
- FAIL_THR, 3, consecutive mismatching samples that move SUSPECT to FAILED (range 2..15).
- RECOVER_THR, 4, consecutive matching samples that move SUSPECT to HEALTHY (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- sample_en  input  1  qualifies q_1..q_3 as a sample this cycle.
- clr_stats  input  1  synchronous clear of counters, FSMs and sticky flags.
- q_1  input  width  replica 1 value.
- q_2  input  width  replica 2 value.
- q_3  input  width  replica 3 value.
- voted_q  output  width  registered majority value.
- valid_out  output  1  1-cycle pulse marking voted_q updated.
- fault_cnt_1  output  CNT_W  mismatches charged to replica 1.
- fault_cnt_2  output  CNT_W  mismatches charged to replica 2.
- fault_cnt_3  output  CNT_W  mismatches charged to replica 3.
- replica_state  output  6  2 bits per replica; [1:0] is replica 1.
- replica_failed  output  3  bit i-1 is 1 when replica i is in FAILED.
- no_majority  output  1  sticky: all three replicas differed on some sample.
- nm_cnt  output  CNT_W  count of no-majority samples.
- fault_irq  output  1  1-cycle pulse.

Behaviour:
- Reset (rst=0, async): all outputs 0; all FSMs HEALTHY; internal streak counters 0.
- Majority selection, combinational from q_1..q_3:
  - q_1 if q_1==q_2 or q_1==q_3;
  - else q_2 if q_2==q_3;
  - else bitwise majority (q_1&q_2)|(q_1&q_3)|(q_2&q_3), and the sample is flagged no-majority.
- Latency: on a sample_en cycle, voted_q, valid_out, counters, states and flags all update at the next rising edge (1 cycle). voted_q holds between samples.
- Mismatch for replica i: sample_en=1, majority exists, and q_i != majority value.
- Replica FSM encoding: HEALTHY=00, SUSPECT=01, FAILED=10. 11 is unused and must recover to HEALTHY.
  - HEALTHY: mismatch -> SUSPECT, fail_streak=1, match_streak=0.
  - SUSPECT, on mismatch: fail_streak+1 and match_streak=0. If the new fail_streak equals FAIL_THR -> FAILED.
  - SUSPECT, on match: match_streak+1 and fail_streak=0. If the new match_streak equals RECOVER_THR -> HEALTHY.
  - FAILED: sticky until clr_stats or reset.
- fault_cnt_i increments on every mismatch in any state and saturates at all-ones; it never wraps.
- No-majority sample:
  - no_majority is set (sticky) and nm_cnt increments (saturating).
  - All replica FSMs, streaks and fault counters hold.
  - voted_q still updates and valid_out still pulses.
- fault_irq pulses for one cycle, coincident with the state update, when:
  - any replica enters FAILED this cycle, or
  - no_majority goes 0 to 1.
  - Multiple simultaneous causes produce a single pulse.
- clr_stats=1: next edge clears counters, streaks, no_majority and replica_failed, and sets all FSMs to HEALTHY.
  - voted_q is held.
  - If sample_en is also 1, clear wins: the sample is discarded and valid_out=0.
- sample_en=0: no state changes; valid_out=0.
- Reset mid-operation aborts everything immediately; there is no partial update.

Optional Feature:
- Macro: TMR_FAULT_LOG_EN.
- When defined, two extra outputs are added:
  - last_fault_id[1:0]: 1..3 is the lowest-index mismatching replica; 3 also marks a no-majority event (nm takes priority).
  - last_fault_val[width-1:0]: the offending q_i, or q_1 for no-majority.
- Both outputs update on every fault sample, are cleared by reset and clr_stats, and hold otherwise.
- When not defined, the ports and their logic are absent.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset: assert rst=0 mid-run with counters nonzero -> all outputs 0 immediately, replica_state=6'b000000.
- Single fault: q=5,5,7 with sample_en for 1 cycle -> next cycle voted_q=5, valid_out=1, fault_cnt_3=1, replica_state[5:4]=01, fault_irq=0.
- Failure: q=9,8,9 for 3 consecutive samples (FAIL_THR=3) -> after the 3rd sample, replica_state[3:2]=10, replica_failed=3'b010, fault_cnt_2=3, fault_irq high exactly 1 cycle.
- Recovery: one sample 4,6,6, then 4 samples 6,6,6 -> replica 1 goes SUSPECT then HEALTHY after the 4th match, fault_cnt_1=1.
- No majority: q=1,2,4 -> voted_q=0, no_majority=1, nm_cnt=1, fault_irq pulse, FSMs and fault counters unchanged. A second 1,2,4 sample -> nm_cnt=2, no fault_irq.
- Saturation/clear: 300 samples 3,0,0 -> fault_cnt_1=255, replica 1 FAILED. Then clr_stats=1 with sample_en=1 -> all stats 0, all HEALTHY, valid_out=0, voted_q unchanged (0).
